hilo_muldiv_unit: RTL

Multi-cycle multiply/divide sequencer that owns the architectural HI and LO registers for the MIPS datapath. It executes MULT, MULTU, DIV, DIVU, MADD and MSUB iteratively over 33 cycles. It also executes MTHI and MTLO in a single cycle. It sits beside the single-cycle ALU in the EX stage and raises Busy so the hazard unit stalls any MFHI/MFLO or new HI/LO operation until the result is committed.

---
 rtl/hilo_muldiv_unit.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/hilo_muldiv_unit.sv
// HI/LO register owner with an iterative radix-2 multiply/divide sequencer.
// MTHI/MTLO complete in one cycle; the other operations take 33 cycles.
module hilo_muldiv_unit (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Flush,
  output logic [31:0] Hi,
  output logic [31:0] Lo,
  output logic        Busy,
  output logic        Done,
  output logic [1:0]  dbg_state
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_MADD  = 3'b110;
  localparam logic [2:0] OP_MSUB  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [2:0]  op_q, op_n;
  logic        neg_res, neg_res_n;   // product / quotient needs negation
  logic        neg_rem, neg_rem_n;   // remainder takes dividend sign
  logic        b_zero, b_zero_n;
  logic [31:0] orig_a, orig_a_n;
  logic [31:0] opb, opb_n;           // multiplicand or divisor magnitude
  logic [63:0] acc, acc_n;
  logic [4:0]  cnt, cnt_n;
  logic [31:0] hi_q, hi_n;
  logic [31:0] lo_q, lo_n;
  logic        done_q, done_n;

  logic        signed_op;
  logic [31:0] abs_a, abs_b;
  logic        is_div;
  logic [32:0] sum33;
  logic [63:0] mul_step;
  logic [32:0] rem_sh;
  logic [31:0] rem_diff;
  logic [63:0] div_step;
  logic [63:0] prod;
  logic [31:0] quot_fix, rem_fix;
  logic [63:0] fin_val;

  always_comb begin
    signed_op = (Op == OP_MULT) || (Op == OP_DIV) || (Op == OP_MADD) || (Op == OP_MSUB);
    abs_a     = (signed_op && A[31]) ? -A : A;
    abs_b     = (signed_op && B[31]) ? -B : B;
  end

  // One radix-2 step for each algorithm; RUN picks the one matching op_q.
  always_comb begin
    is_div   = (op_q == OP_DIV) || (op_q == OP_DIVU);
    sum33    = {1'b0, acc[63:32]} + {1'b0, opb};
    mul_step = acc[0] ? {sum33, acc[31:1]} : {1'b0, acc[63:1]};
    rem_sh   = acc[63:31];
    rem_diff = rem_sh[31:0] - opb;
    div_step = (rem_sh >= {1'b0, opb}) ? {rem_diff, acc[30:0], 1'b1}
                                       : {acc[62:0], 1'b0};
  end

  always_comb begin
    prod     = neg_res ? -acc : acc;
    quot_fix = neg_res ? -acc[31:0]  : acc[31:0];
    rem_fix  = neg_rem ? -acc[63:32] : acc[63:32];
    case (op_q)
      OP_MADD:  fin_val = {hi_q, lo_q} + prod;
      OP_MSUB:  fin_val = {hi_q, lo_q} - prod;
      OP_DIV,
      OP_DIVU:  fin_val = b_zero ? {orig_a, 32'hFFFF_FFFF} : {rem_fix, quot_fix};
      default:  fin_val = prod;
    endcase
  end

  always_comb begin
    state_n   = state;
    op_n      = op_q;
    neg_res_n = neg_res;
    neg_rem_n = neg_rem;
    b_zero_n  = b_zero;
    orig_a_n  = orig_a;
    opb_n     = opb;
    acc_n     = acc;
    cnt_n     = cnt;
    hi_n      = hi_q;
    lo_n      = lo_q;
    done_n    = 1'b0;
    case (state)
      S_IDLE: begin
        // A flush in IDLE also swallows a simultaneous Start.
        if (Start && !Flush) begin
          if (Op == OP_MTHI) begin
            hi_n = A;
          end else if (Op == OP_MTLO) begin
            lo_n = A;
          end else begin
            op_n      = Op;
            neg_res_n = signed_op && (A[31] ^ B[31]);
            neg_rem_n = signed_op && A[31];
            b_zero_n  = (B == 32'd0);
            orig_a_n  = A;
            cnt_n     = 5'd0;
            if ((Op == OP_DIV) || (Op == OP_DIVU)) begin
              opb_n = abs_b;
              acc_n = {32'd0, abs_a};
            end else begin
              opb_n = abs_a;
              acc_n = {32'd0, abs_b};
            end
            state_n = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (Flush) begin
          state_n = S_IDLE;
          cnt_n   = 5'd0;
        end else begin
          acc_n = is_div ? div_step : mul_step;
          cnt_n = cnt + 5'd1;
          if (cnt == 5'd31) state_n = S_FIN;
        end
      end
      S_FIN: begin
        state_n = S_IDLE;
        cnt_n   = 5'd0;
        if (!Flush) begin
          hi_n   = fin_val[63:32];
          lo_n   = fin_val[31:0];
          done_n = 1'b1;
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = 5'd0;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= S_IDLE;
      op_q    <= 3'd0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      b_zero  <= 1'b0;
      orig_a  <= 32'd0;
      opb     <= 32'd0;
      acc     <= 64'd0;
      cnt     <= 5'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      op_q    <= op_n;
      neg_res <= neg_res_n;
      neg_rem <= neg_rem_n;
      b_zero  <= b_zero_n;
      orig_a  <= orig_a_n;
      opb     <= opb_n;
      acc     <= acc_n;
      cnt     <= cnt_n;
      hi_q    <= hi_n;
      lo_q    <= lo_n;
      done_q  <= done_n;
    end
  end

  assign Hi        = hi_q;
  assign Lo        = lo_q;
  assign Busy      = (state != S_IDLE);
  assign Done      = done_q;
  assign dbg_state = state;

endmodule
